// File: rtl/stream_fifo.sv
// ---------------------------------------------------------------------------
// stream_fifo
//   Single-clock synchronous FIFO with occupancy and threshold flags and
//   single-cycle error pulses. Supports a standard registered-read mode and
//   a first-word-fall-through mode, selected by the FWFT parameter.
//
// Parameters
//   DATA_WIDTH   data word width in bits
//   DEPTH        number of storage entries (power of two, >= 2)
//   AF_THRESH    almost_full level,  legal 1..DEPTH-1
//   AE_THRESH    almost_empty level, legal 0..DEPTH-1
//   FWFT         0: dataOut is loaded on an accepted read
//                1: dataOut shows the head word whenever not empty
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   clear         synchronous flush, wins over w_en and r_en
//   w_en, dataIn  write request and data
//   r_en          read request (standard) / head acknowledge (FWFT)
//   dataOut       read data
//   empty, full   occupancy flags, registered
//   almost_empty  count <= AE_THRESH, registered
//   almost_full   count >= AF_THRESH, registered
//   count         occupancy 0..DEPTH
//   overflow      one-cycle pulse after a write attempted while full
//   underflow     one-cycle pulse after a read attempted while empty
// ---------------------------------------------------------------------------
module stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     w_en,
  input  logic [DATA_WIDTH-1:0]    dataIn,
  input  logic                     r_en,
  output logic [DATA_WIDTH-1:0]    dataOut,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_LVL    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0]   AE_LVL    = (AW+1)'(AE_THRESH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  // Elaboration-time parameter legality checks
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH - 1) begin : g_bad_af
    $error("stream_fifo: AF_THRESH must be in 1..DEPTH-1");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("stream_fifo: AE_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
    $error("stream_fifo: FWFT must be 0 or 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("stream_fifo: DATA_WIDTH must be at least 1");
  end

  // Occupancy after one edge given which transfers were accepted.
  // A simultaneous read and write leaves the count unchanged.
  function automatic logic [AW:0] next_count(input logic [AW:0] cur,
                                             input logic        wr,
                                             input logic        rd);
    logic [AW:0] res;
    res = cur;
    if (wr && !rd) res = cur + CNT_ONE;
    if (rd && !wr) res = cur - CNT_ONE;
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [AW:0]           cnt_nxt;

  // Flags are registered, so full/empty here reflect the current count and
  // the same-cycle read cannot make room for a write (or vice versa).
  always_comb begin
    wr_acc  = w_en && !full  && !clear;
    rd_acc  = r_en && !empty && !clear;
    cnt_nxt = clear ? '0 : next_count(count, wr_acc, rd_acc);
  end

  // Storage is deliberately left out of reset and clear; only the pointers
  // decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= dataIn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (clear) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_acc) wptr <= wptr + PTR_ONE;
        if (rd_acc) rptr <= rptr + PTR_ONE;
      end
      count        <= cnt_nxt;
      empty        <= (cnt_nxt == '0);
      full         <= (cnt_nxt == CNT_DEPTH);
      almost_empty <= (cnt_nxt <= AE_LVL);
      almost_full  <= (cnt_nxt >= AF_LVL);
      overflow     <= w_en && full  && !clear;
      underflow    <= r_en && empty && !clear;
    end
  end

  if (FWFT == 0) begin : g_std_read
    logic [DATA_WIDTH-1:0] rd_data_p1;

    // Read stage: head word captured on an accepted read, held otherwise
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_data_p1 <= '0;
      end else if (clear) begin
        rd_data_p1 <= '0;
      end else if (rd_acc) begin
        rd_data_p1 <= mem[rptr];
      end
    end

    assign dataOut = rd_data_p1;
  end else begin : g_fwft_read
    // Head entry shown directly; forced to zero while empty so that reset
    // and clear both blank the output through the empty flag.
    assign dataOut = empty ? '0 : mem[rptr];
  end

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

  logic       clk;
  logic       reset;

  logic       a_clear, a_w_en, a_r_en;
  logic [7:0] a_din, a_dout;
  logic       a_empty, a_full, a_ae, a_af, a_ov, a_uf;
  logic [4:0] a_count;

  logic       b_clear, b_w_en, b_r_en;
  logic [7:0] b_din, b_dout;
  logic       b_empty, b_full, b_ae, b_af, b_ov, b_uf;
  logic [4:0] b_count;

  int n_checks;
  int n_fail;

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .clear(a_clear), .w_en(a_w_en), .dataIn(a_din),
    .r_en(a_r_en), .dataOut(a_dout), .empty(a_empty), .full(a_full),
    .almost_empty(a_ae), .almost_full(a_af), .count(a_count),
    .overflow(a_ov), .underflow(a_uf)
  );

  stream_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(4), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .clear(b_clear), .w_en(b_w_en), .dataIn(b_din),
    .r_en(b_r_en), .dataOut(b_dout), .empty(b_empty), .full(b_full),
    .almost_empty(b_ae), .almost_full(b_af), .count(b_count),
    .overflow(b_ov), .underflow(b_uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running, wanted finished");
    $fatal(1, "timeout");
  end

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_w_en = 1'b0; a_r_en = 1'b0; a_clear = 1'b0; a_din = 8'h00;
  endtask

  task automatic a_write_seq(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      a_w_en = 1'b1; a_din = first + 8'(i);
      tick();
    end
    a_w_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_idle();
    b_w_en = 1'b0; b_r_en = 1'b0; b_clear = 1'b0; b_din = 8'h00;
    #1 reset = 1'b1;
    #2;
    n_checks++;
    if ({a_count, a_empty, a_ae, a_full, a_af, a_ov, a_uf} !== {5'd0, 6'b110000}) begin
      n_fail++;
      $display("FAIL reset_flags: got cnt=%0d e=%b ae=%b f=%b af=%b ov=%b uf=%b, wanted cnt=0 e=1 ae=1 f=0 af=0 ov=0 uf=0",
               a_count, a_empty, a_ae, a_full, a_af, a_ov, a_uf);
    end
    n_checks++;
    if (a_dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h wanted 00", a_dout); end
    n_checks++;
    if (b_dout !== 8'h00 || b_empty !== 1'b1) begin
      n_fail++; $display("FAIL reset_fwft: got dout=%h e=%b wanted dout=00 e=1", b_dout, b_empty);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      a_w_en = 1'b1; a_din = 8'(i + 1);
      tick();
      n_checks++;
      if (a_count !== 5'(i + 1) || a_ae !== ((i + 1) <= 4) || a_af !== ((i + 1) >= 12)) begin
        n_fail++;
        $display("FAIL fill_thresh: got cnt=%0d ae=%b af=%b, wanted cnt=%0d ae=%b af=%b",
                 a_count, a_ae, a_af, i + 1, ((i + 1) <= 4), ((i + 1) >= 12));
      end
    end
    a_w_en = 1'b0;
    n_checks++;
    if (a_full !== 1'b1 || a_empty !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got full=%b empty=%b wanted full=1 empty=0", a_full, a_empty);
    end
    for (int i = 0; i < 16; i++) begin
      a_r_en = 1'b1;
      tick();
      n_checks++;
      if (a_dout !== 8'(i + 1)) begin
        n_fail++; $display("FAIL drain_data[%0d]: got %h wanted %h", i, a_dout, 8'(i + 1));
      end
    end
    a_r_en = 1'b0;
    n_checks++;
    if (a_empty !== 1'b1 || a_count !== 5'd0 || a_full !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: got e=%b cnt=%0d f=%b wanted e=1 cnt=0 f=0", a_empty, a_count, a_full);
    end
  endtask

  task automatic test_overflow();
    a_write_seq(8'h01, 16);
    a_w_en = 1'b1; a_din = 8'hAA;
    tick();
    a_w_en = 1'b0;
    n_checks++;
    if (a_ov !== 1'b1 || a_count !== 5'd16) begin
      n_fail++; $display("FAIL overflow_pulse: got ov=%b cnt=%0d wanted ov=1 cnt=16", a_ov, a_count);
    end
    tick();
    n_checks++;
    if (a_ov !== 1'b0) begin n_fail++; $display("FAIL overflow_width: got ov=%b wanted 0", a_ov); end
    // write rejected while full even with a same-cycle read
    a_w_en = 1'b1; a_r_en = 1'b1; a_din = 8'hAA;
    tick();
    a_w_en = 1'b0; a_r_en = 1'b0;
    n_checks++;
    if (a_dout !== 8'h01 || a_count !== 5'd15 || a_full !== 1'b0 || a_ov !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rdwr: got dout=%h cnt=%0d f=%b ov=%b wanted dout=01 cnt=15 f=0 ov=1",
               a_dout, a_count, a_full, a_ov);
    end
    for (int i = 0; i < 15; i++) begin
      a_r_en = 1'b1;
      tick();
      n_checks++;
      if (a_dout !== 8'(i + 2)) begin
        n_fail++; $display("FAIL overflow_drain[%0d]: got %h wanted %h", i, a_dout, 8'(i + 2));
      end
    end
    a_r_en = 1'b0;
    n_checks++;
    if (a_empty !== 1'b1) begin n_fail++; $display("FAIL overflow_end: got empty=%b wanted 1", a_empty); end
  endtask

  task automatic test_back_to_back();
    a_write_seq(8'h20, 8);
    for (int i = 0; i < 40; i++) begin
      a_w_en = 1'b1; a_r_en = 1'b1; a_din = 8'h28 + 8'(i);
      tick();
      n_checks++;
      if (a_dout !== 8'h20 + 8'(i) || a_count !== 5'd8) begin
        n_fail++;
        $display("FAIL b2b[%0d]: got dout=%h cnt=%0d wanted dout=%h cnt=8", i, a_dout, a_count, 8'h20 + 8'(i));
      end
    end
    a_w_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_r_en = 1'b1;
      tick();
      n_checks++;
      if (a_dout !== 8'h48 + 8'(i)) begin
        n_fail++; $display("FAIL b2b_drain[%0d]: got %h wanted %h", i, a_dout, 8'h48 + 8'(i));
      end
    end
    a_r_en = 1'b0;
  endtask

  task automatic test_underflow();
    a_r_en = 1'b1;
    tick();
    a_r_en = 1'b0;
    n_checks++;
    if (a_uf !== 1'b1 || a_count !== 5'd0 || a_dout !== 8'h4F) begin
      n_fail++; $display("FAIL underflow_pulse: got uf=%b cnt=%0d dout=%h wanted uf=1 cnt=0 dout=4f", a_uf, a_count, a_dout);
    end
    tick();
    n_checks++;
    if (a_uf !== 1'b0) begin n_fail++; $display("FAIL underflow_width: got uf=%b wanted 0", a_uf); end
    // read rejected while empty, same-cycle write still lands
    a_w_en = 1'b1; a_r_en = 1'b1; a_din = 8'h77;
    tick();
    a_w_en = 1'b0;
    n_checks++;
    if (a_uf !== 1'b1 || a_count !== 5'd1 || a_empty !== 1'b0) begin
      n_fail++; $display("FAIL empty_rdwr: got uf=%b cnt=%0d e=%b wanted uf=1 cnt=1 e=0", a_uf, a_count, a_empty);
    end
    tick();
    a_r_en = 1'b0;
    n_checks++;
    if (a_dout !== 8'h77 || a_uf !== 1'b0 || a_empty !== 1'b1) begin
      n_fail++; $display("FAIL empty_rdwr_read: got dout=%h uf=%b e=%b wanted dout=77 uf=0 e=1", a_dout, a_uf, a_empty);
    end
  endtask

  task automatic test_fwft();
    b_w_en = 1'b1; b_din = 8'h5C;
    tick();
    b_w_en = 1'b0;
    n_checks++;
    if (b_dout !== 8'h5C || b_empty !== 1'b0) begin
      n_fail++; $display("FAIL fwft_fall: got dout=%h e=%b wanted dout=5c e=0", b_dout, b_empty);
    end
    b_r_en = 1'b1;
    tick();
    b_r_en = 1'b0;
    n_checks++;
    if (b_dout !== 8'h00 || b_empty !== 1'b1) begin
      n_fail++; $display("FAIL fwft_pop: got dout=%h e=%b wanted dout=00 e=1", b_dout, b_empty);
    end
    b_w_en = 1'b1; b_din = 8'h11;
    tick();
    b_din = 8'h22;
    tick();
    b_w_en = 1'b0;
    n_checks++;
    if (b_dout !== 8'h11 || b_count !== 5'd2) begin
      n_fail++; $display("FAIL fwft_head: got dout=%h cnt=%0d wanted dout=11 cnt=2", b_dout, b_count);
    end
    b_r_en = 1'b1;
    tick();
    b_r_en = 1'b0;
    n_checks++;
    if (b_dout !== 8'h22) begin n_fail++; $display("FAIL fwft_next: got %h wanted 22", b_dout); end
    b_r_en = 1'b1;
    tick();
    b_r_en = 1'b0;
    n_checks++;
    if (b_dout !== 8'h00 || b_empty !== 1'b1) begin
      n_fail++; $display("FAIL fwft_drain: got dout=%h e=%b wanted dout=00 e=1", b_dout, b_empty);
    end
  endtask

  task automatic test_reset_mid();
    a_write_seq(8'h30, 9);
    n_checks++;
    if (a_count !== 5'd9 || a_ae !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset: got cnt=%0d ae=%b wanted cnt=9 ae=0", a_count, a_ae);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({a_count, a_empty, a_ae, a_full, a_af, a_ov, a_uf} !== {5'd0, 6'b110000} || a_dout !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d e=%b ae=%b f=%b af=%b dout=%h, wanted cnt=0 e=1 ae=1 f=0 af=0 dout=00",
               a_count, a_empty, a_ae, a_full, a_af, a_dout);
    end
    tick();
    #2 reset = 1'b0;
    tick();
    a_write_seq(8'hC1, 1);
    a_r_en = 1'b1;
    tick();
    a_r_en = 1'b0;
    n_checks++;
    if (a_dout !== 8'hC1 || a_empty !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_first: got dout=%h e=%b wanted dout=c1 e=1", a_dout, a_empty);
    end
  endtask

  task automatic test_clear();
    a_write_seq(8'h01, 16);
    a_clear = 1'b1; a_w_en = 1'b1; a_r_en = 1'b1; a_din = 8'hEE;
    tick();
    n_checks++;
    if (a_count !== 5'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_ov !== 1'b0 || a_uf !== 1'b0 || a_dout !== 8'h00) begin
      n_fail++;
      $display("FAIL clear_full: got cnt=%0d e=%b f=%b ov=%b uf=%b dout=%h wanted cnt=0 e=1 f=0 ov=0 uf=0 dout=00",
               a_count, a_empty, a_full, a_ov, a_uf, a_dout);
    end
    tick();
    n_checks++;
    if (a_count !== 5'd0 || a_uf !== 1'b0 || a_ov !== 1'b0) begin
      n_fail++; $display("FAIL clear_empty: got cnt=%0d uf=%b ov=%b wanted cnt=0 uf=0 ov=0", a_count, a_uf, a_ov);
    end
    a_idle();
    a_write_seq(8'h99, 1);
    a_r_en = 1'b1;
    tick();
    a_r_en = 1'b0;
    n_checks++;
    if (a_dout !== 8'h99 || a_count !== 5'd0) begin
      n_fail++; $display("FAIL post_clear: got dout=%h cnt=%0d wanted dout=99 cnt=0", a_dout, a_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_back_to_back();
    test_underflow();
    test_fwft();
    test_reset_mid();
    test_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
